// File: rtl/gpu_irq_ctrl.sv
// Edge-triggered, priority-encoded interrupt controller with a registered CPU interrupt line.
// Build option GPU_IRQ_HOLDOFF_EN adds a post-acknowledge holdoff state and down-counter.
module gpu_irq_ctrl #(
  parameter int NSRC           = 4,
  parameter int HOLDOFF_CYCLES = 8
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic [NSRC-1:0] i_src,
  input  logic [NSRC-1:0] i_mask,
  input  logic            i_ack,
  input  logic            i_clrAll,
  output logic            o_irq,
  output logic [2:0]      o_cause,
  output logic [NSRC-1:0] o_pending
);

  if (NSRC < 1 || NSRC > 8 || HOLDOFF_CYCLES < 1 || HOLDOFF_CYCLES > 255) begin : g_bad_param
    $error("gpu_irq_ctrl: parameter out of range");
  end

`ifdef GPU_IRQ_HOLDOFF_EN
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ASSERT  = 2'd1,
    ST_HOLDOFF = 2'd2
  } state_t;
  localparam logic [7:0] HOLDOFF_LOAD = 8'(HOLDOFF_CYCLES - 1);
  logic [7:0] cnt_reg;
`else
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ASSERT = 2'd1
  } state_t;
`endif

  state_t          state_reg;
  logic            irq_reg;
  logic            armed_reg;
  logic [NSRC-1:0] src_q_reg;
  logic [NSRC-1:0] pending_reg;
  logic [NSRC-1:0] pending_next;
  logic [NSRC-1:0] set_req;
  logic [NSRC-1:0] ack_hit;
  logic [NSRC-1:0] active;
  logic            active_any;
  logic            ack_fire;
  logic [2:0]      cause;

  assign active     = pending_reg & i_mask;
  assign active_any = |active;
  assign ack_fire   = (state_reg == ST_ASSERT) && i_ack && active_any;

  // Lowest set index of the enabled pending bits wins.
  always_comb begin
    cause = 3'd0;
    for (int k = NSRC - 1; k >= 0; k--) begin
      if (active[k]) cause = 3'(k);
    end
  end

  // armed_reg blanks the first edge after reset so a level held through release is not an event.
  genvar gi;
  for (gi = 0; gi < NSRC; gi++) begin : g_bit
    assign set_req[gi]      = armed_reg & i_src[gi] & ~src_q_reg[gi];
    assign ack_hit[gi]      = ack_fire && (cause == 3'(gi));
    assign pending_next[gi] = set_req[gi] ? 1'b1 :
                              ((i_clrAll || ack_hit[gi]) ? 1'b0 : pending_reg[gi]);
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      armed_reg   <= 1'b0;
      src_q_reg   <= '0;
      pending_reg <= '0;
    end else begin
      armed_reg   <= 1'b1;
      src_q_reg   <= i_src;
      pending_reg <= pending_next;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_reg <= ST_IDLE;
      irq_reg   <= 1'b0;
`ifdef GPU_IRQ_HOLDOFF_EN
      cnt_reg   <= 8'd0;
`endif
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (active_any) begin
            state_reg <= ST_ASSERT;
            irq_reg   <= 1'b1;
          end
        end
        ST_ASSERT: begin
          if (!active_any) begin
            state_reg <= ST_IDLE;
            irq_reg   <= 1'b0;
          end else if (i_ack) begin
            irq_reg <= 1'b0;
`ifdef GPU_IRQ_HOLDOFF_EN
            state_reg <= ST_HOLDOFF;
            cnt_reg   <= HOLDOFF_LOAD;
`else
            state_reg <= ST_IDLE;
`endif
          end
        end
`ifdef GPU_IRQ_HOLDOFF_EN
        // Leaving as the count reaches 0 makes HOLDOFF plus the IDLE cycle span HOLDOFF_CYCLES.
        ST_HOLDOFF: begin
          irq_reg <= 1'b0;
          if (cnt_reg <= 8'd1) begin
            state_reg <= ST_IDLE;
            cnt_reg   <= 8'd0;
          end else begin
            cnt_reg <= cnt_reg - 8'd1;
          end
        end
`endif
        default: begin
          state_reg <= ST_IDLE;
          irq_reg   <= 1'b0;
        end
      endcase
    end
  end

  assign o_irq     = irq_reg;
  assign o_cause   = cause;
  assign o_pending = pending_reg;

endmodule

// File: tb/tb_gpu_irq_ctrl.sv
// Directed self-checking bench for gpu_irq_ctrl (NSRC=4, HOLDOFF_CYCLES=8).
module tb_gpu_irq_ctrl;

`ifdef GPU_IRQ_HOLDOFF_EN
  localparam int LOW = 8;
`else
  localparam int LOW = 1;
`endif

  logic       clk;
  logic       rst;
  logic [3:0] src;
  logic [3:0] mask;
  logic       ack;
  logic       clr_all;
  logic       irq;
  logic [2:0] cause;
  logic [3:0] pending;

  int n_checks = 0;
  int n_fail   = 0;

  gpu_irq_ctrl #(.NSRC(4), .HOLDOFF_CYCLES(8)) dut (
    .i_clk     (clk),
    .i_rst     (rst),
    .i_src     (src),
    .i_mask    (mask),
    .i_ack     (ack),
    .i_clrAll  (clr_all),
    .o_irq     (irq),
    .o_cause   (cause),
    .o_pending (pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic count_low(output int n);
    n = 0;
    while (irq === 1'b0 && n < 50) begin
      n++;
      tick();
    end
  endtask

  task automatic test_reset();
    #3;
    n_checks++;
    if (irq !== 1'b0 || cause !== 3'd0 || pending !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_state: irq=%0b cause=%0d pending=%b want 0 0 0000", irq, cause, pending);
    end
    tick();
    rst = 1'b0;
    tick();
    $display("test_reset done");
  endtask

  task automatic test_basic();
    src = 4'b0100;
    tick();
    n_checks++;
    if (pending !== 4'b0100 || irq !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_pending: pending=%b irq=%0b want 0100 0", pending, irq);
    end
    tick();
    n_checks++;
    if (irq !== 1'b1 || cause !== 3'd2) begin
      n_fail++;
      $display("FAIL basic_irq: irq=%0b cause=%0d want 1 2", irq, cause);
    end
    ack = 1'b1;
    tick();
    ack = 1'b0;
    src = 4'b0000;
    n_checks++;
    if (pending !== 4'b0000 || irq !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_ack: pending=%b irq=%0b want 0000 0", pending, irq);
    end
    tick();
    $display("test_basic done");
  endtask

  task automatic test_back_to_back();
    int n;
    src = 4'b1010;
    tick();
    tick();
    n_checks++;
    if (irq !== 1'b1 || cause !== 3'd1 || pending !== 4'b1010) begin
      n_fail++;
      $display("FAIL b2b_first: irq=%0b cause=%0d pending=%b want 1 1 1010", irq, cause, pending);
    end
    ack = 1'b1;
    tick();
    ack = 1'b0;
    n_checks++;
    if (pending !== 4'b1000) begin
      n_fail++;
      $display("FAIL b2b_clear1: pending=%b want 1000", pending);
    end
    count_low(n);
    n_checks++;
    if (n != LOW) begin
      n_fail++;
      $display("FAIL b2b_low_cycles: got %0d want %0d", n, LOW);
    end
    n_checks++;
    if (irq !== 1'b1 || cause !== 3'd3) begin
      n_fail++;
      $display("FAIL b2b_second: irq=%0b cause=%0d want 1 3", irq, cause);
    end
    ack = 1'b1;
    tick();
    ack = 1'b0;
    src = 4'b0000;
    n_checks++;
    if (pending !== 4'b0000) begin
      n_fail++;
      $display("FAIL b2b_clear3: pending=%b want 0000", pending);
    end
    for (int i = 0; i < LOW + 2; i++) tick();
    n_checks++;
    if (irq !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_idle: irq=%0b want 0", irq);
    end
    $display("test_back_to_back done");
  endtask

  task automatic test_set_wins();
    int n;
    src = 4'b0001;
    tick();
    tick();
    n_checks++;
    if (irq !== 1'b1 || cause !== 3'd0) begin
      n_fail++;
      $display("FAIL setwin_assert: irq=%0b cause=%0d want 1 0", irq, cause);
    end
    src = 4'b0000;
    tick();
    src = 4'b0001;
    ack = 1'b1;
    tick();
    ack = 1'b0;
    n_checks++;
    if (pending !== 4'b0001 || irq !== 1'b0) begin
      n_fail++;
      $display("FAIL setwin_pending: pending=%b irq=%0b want 0001 0", pending, irq);
    end
    count_low(n);
    n_checks++;
    if (n != LOW || irq !== 1'b1 || cause !== 3'd0) begin
      n_fail++;
      $display("FAIL setwin_reassert: low=%0d irq=%0b cause=%0d want %0d 1 0", n, irq, cause, LOW);
    end
    ack = 1'b1;
    tick();
    ack = 1'b0;
    src = 4'b0000;
    for (int i = 0; i < LOW + 2; i++) tick();
    $display("test_set_wins done");
  endtask

  task automatic test_mask();
    mask = 4'b1011;
    src  = 4'b0100;
    tick();
    tick();
    n_checks++;
    if (irq !== 1'b0 || pending !== 4'b0100 || cause !== 3'd0) begin
      n_fail++;
      $display("FAIL mask_hold: irq=%0b pending=%b cause=%0d want 0 0100 0", irq, pending, cause);
    end
    mask = 4'b1111;
    #1;
    n_checks++;
    if (cause !== 3'd2 || irq !== 1'b0) begin
      n_fail++;
      $display("FAIL mask_cause_comb: cause=%0d irq=%0b want 2 0", cause, irq);
    end
    tick();
    n_checks++;
    if (irq !== 1'b1) begin
      n_fail++;
      $display("FAIL mask_enable: irq=%0b want 1", irq);
    end
    mask = 4'b1011;
    tick();
    n_checks++;
    if (irq !== 1'b0 || pending !== 4'b0100) begin
      n_fail++;
      $display("FAIL mask_drop: irq=%0b pending=%b want 0 0100", irq, pending);
    end
    ack = 1'b1;
    tick();
    ack = 1'b0;
    n_checks++;
    if (pending !== 4'b0100) begin
      n_fail++;
      $display("FAIL ack_in_idle: pending=%b want 0100", pending);
    end
    clr_all = 1'b1;
    tick();
    clr_all = 1'b0;
    n_checks++;
    if (pending !== 4'b0000) begin
      n_fail++;
      $display("FAIL clr_all: pending=%b want 0000", pending);
    end
    mask = 4'b1111;
    src  = 4'b0000;
    tick();
    tick();
    n_checks++;
    if (irq !== 1'b0) begin
      n_fail++;
      $display("FAIL clr_all_idle: irq=%0b want 0", irq);
    end
    $display("test_mask done");
  endtask

  task automatic test_reset_mid();
    src = 4'b0010;
    tick();
    tick();
    n_checks++;
    if (irq !== 1'b1 || cause !== 3'd1) begin
      n_fail++;
      $display("FAIL rstmid_assert: irq=%0b cause=%0d want 1 1", irq, cause);
    end
    #2;
    rst = 1'b1;
    #1;
    n_checks++;
    if (irq !== 1'b0 || pending !== 4'b0000 || cause !== 3'd0) begin
      n_fail++;
      $display("FAIL rstmid_async: irq=%0b pending=%b cause=%0d want 0 0000 0", irq, pending, cause);
    end
    tick();
    rst = 1'b0;
    tick();
    tick();
    tick();
    n_checks++;
    if (irq !== 1'b0 || pending !== 4'b0000) begin
      n_fail++;
      $display("FAIL rstmid_held_src: irq=%0b pending=%b want 0 0000", irq, pending);
    end
    src = 4'b0000;
    tick();
    src = 4'b0010;
    tick();
    n_checks++;
    if (pending !== 4'b0010) begin
      n_fail++;
      $display("FAIL rstmid_retoggle: pending=%b want 0010", pending);
    end
    tick();
    n_checks++;
    if (irq !== 1'b1 || cause !== 3'd1) begin
      n_fail++;
      $display("FAIL rstmid_irq: irq=%0b cause=%0d want 1 1", irq, cause);
    end
    ack = 1'b1;
    tick();
    ack = 1'b0;
    src = 4'b0000;
    tick();
    $display("test_reset_mid done");
  endtask

  initial begin
    rst     = 1'b1;
    src     = 4'b0000;
    mask    = 4'b1111;
    ack     = 1'b0;
    clr_all = 1'b0;
    test_reset();
    test_basic();
    test_back_to_back();
    test_set_wins();
    test_mask();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/gpu_irq_ctrl.md
GPU_IRQ_CTRL -- requirements
Module: gpu_irq_ctrl

Interface
REQ-001 Parameter NSRC, default 4: number of interrupt sources, range 1..8.
REQ-002 Parameter HOLDOFF_CYCLES, default 8: forced o_irq-low cycles after an acknowledge, range 1..255; used only when GPU_IRQ_HOLDOFF_EN is defined.
REQ-003 i_clk  in  1  single clock; all state on its rising edge.
REQ-004 i_rst  in  1  reset, asynchronous, active-high.
REQ-005 i_src  in  NSRC  source request levels; bit 0 is highest priority.
REQ-006 i_mask  in  NSRC  enable per source; 1 = may raise o_irq.
REQ-007 i_ack  in  1  one-cycle acknowledge of the cause currently on o_cause.
REQ-008 i_clrAll  in  1  one-cycle clear of all pending bits (GP1 reset path).
REQ-009 o_irq  out  1  registered interrupt line to the CPU.
REQ-010 o_cause  out  3  index of the highest-priority enabled pending source; 0 when none.
REQ-011 o_pending  out  NSRC  raw pending register, unmasked.

Function
REQ-012 Per source, a registered copy src_q SHALL detect rising edges: set request = i_src & ~src_q.
REQ-013 pending[k] SHALL be set on the edge where its set request is 1, independent of i_mask.
REQ-014 A set request and a clear (ack or i_clrAll) on the same bit in the same cycle SHALL leave that bit set; the set wins.
REQ-015 Active = pending & i_mask; o_cause SHALL be the lowest set index of Active, combinational from registered pending and i_mask.
REQ-016 The FSM SHALL have exactly the states IDLE, ASSERT and HOLDOFF; o_irq = 1 only in ASSERT.
REQ-017 IDLE -> ASSERT on the next edge when Active != 0; the source edge therefore reaches o_irq two edges after i_src rises.
REQ-018 ASSERT with i_ack = 1 SHALL clear pending[o_cause] and latch o_cause for the duration of the cycle.
REQ-019 On that ack the next state SHALL be HOLDOFF if the macro is defined, otherwise IDLE.
REQ-020 ASSERT with Active == 0, whether from a mask change or i_clrAll, SHALL go to IDLE with no ack required.
REQ-021 i_ack in IDLE or HOLDOFF SHALL be ignored and SHALL clear nothing.
REQ-022 i_clrAll SHALL clear all pending bits in any state; the FSM state is not otherwise affected.
REQ-023 HOLDOFF SHALL load an 8-bit down-counter with HOLDOFF_CYCLES-1 and return to IDLE when it reaches 0.
REQ-024 Sources arriving during HOLDOFF SHALL be latched into pending and serviced from IDLE afterward.
REQ-025 Mask changes SHALL take effect on Active in the same cycle and SHALL never alter pending.

Reset
REQ-026 Assertion of i_rst SHALL immediately force the FSM to IDLE and clear pending, src_q and the counter to 0; o_irq = 0 and o_cause = 0.
REQ-027 A source held high through reset release SHALL NOT generate an event: src_q resets to 0, but the first post-reset edge samples src_q, so an event requires a low-to-high transition after release.
REQ-028 Reset asserted mid-ASSERT or mid-HOLDOFF SHALL abandon the cycle with no residual pending state.

Configuration
REQ-029 Macro GPU_IRQ_HOLDOFF_EN: when defined, the HOLDOFF state and counter are built.
REQ-030 When GPU_IRQ_HOLDOFF_EN is not defined, HOLDOFF and the counter SHALL be absent; o_irq SHALL be low for exactly one cycle (IDLE) between acknowledged events.

Verification
REQ-031 Reset release, i_mask=4'hF, i_src[2] rises at edge 0 -> pending=4'b0100 after edge 0, o_irq=1 and o_cause=2 after edge 1.
REQ-032 i_src[1] and i_src[3] rise together, then ack -> o_cause=1, then o_irq low HOLDOFF_CYCLES (8) cycles, then o_irq=1 with o_cause=3.
REQ-033 i_src[0] rises in the same cycle as an ack for cause 0 -> pending[0] remains 1 and o_irq reasserts after the holdoff.
REQ-034 Pending source 2 with i_mask=4'b1011 -> o_irq=0 and o_pending=4'b0100; set i_mask[2] -> o_irq=1 one edge later.
REQ-035 i_rst pulsed during ASSERT -> o_irq=0 and o_pending=0 immediately; i_src held high through release -> no event until the source toggles low then high.
REQ-036 Build without GPU_IRQ_HOLDOFF_EN, two pending sources, ack -> o_irq low exactly 1 cycle, then high with the next o_cause.
